usb_tx_packet_ctrl: RTL

Transmit-side packet sequencer for the USB endpoint. It frames one packet as SYNC, PID, optional DATA payload, CRC16 low byte, CRC16 high byte and EOP. It sequences the external byte counter through load_buffer and decrement, and pops payload bytes from the TX FIFO. It hands bytes to the bit serializer over a valid/ready handshake and drives the external CRC16 generator.

---
 rtl/usb_tx_packet_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/usb_tx_packet_ctrl.sv
// rtl/usb_tx_packet_ctrl.sv - USB transmit packet sequencer (SYNC, PID, DATA, CRC16, EOP)
module usb_tx_packet_ctrl #(
  parameter int          LEN_BITS  = 6,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          pid,
  input  logic                send_data,
  input  logic [LEN_BITS-1:0] packet_length,
  input  logic                abort,
  output logic                load_buffer,
  output logic                decrement,
  input  logic                cnt_one,
  input  logic                cnt_zero,
  output logic                fifo_rd,
  input  logic [7:0]          fifo_data,
  output logic                crc_clr,
  output logic                crc_update,
  input  logic [15:0]         crc16,
  output logic [7:0]          tx_byte,
  output logic                tx_valid,
  output logic                tx_eop,
  input  logic                tx_ready,
  output logic                tx_busy,
  output logic                tx_done,
  output logic                tx_aborted,
  output logic                len_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_PID    = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CRC_LO = 3'd4;
  localparam logic [2:0] S_CRC_HI = 3'd5;
  localparam logic [2:0] S_EOP    = 3'd6;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] pid_q;
  logic       send_data_q;
  logic       len_err_q;
  logic       accept_start;
  logic       data_xfer;
  logic       underflow;

  // The byte counter consumes packet_length directly; it is only carried here.
  logic unused_packet_length;
  assign unused_packet_length = ^packet_length;

  assign tx_busy      = (state != S_IDLE);
  assign accept_start = !tx_busy && start && !rst;
  assign underflow    = (state == S_DATA) && cnt_zero && !abort;
  assign data_xfer    = (state == S_DATA) && !cnt_zero && tx_ready && !abort;

  assign load_buffer = accept_start;
  assign crc_clr     = accept_start;
  assign decrement   = data_xfer;
  assign fifo_rd     = data_xfer;
  assign crc_update  = data_xfer;
  assign tx_done     = (state == S_EOP) && tx_ready && !abort;
  assign tx_aborted  = tx_busy && abort;
  assign len_err     = len_err_q;

  assign tx_valid = (state == S_SYNC) || (state == S_PID) || (state == S_DATA) ||
                    (state == S_CRC_LO) || (state == S_CRC_HI);
  assign tx_eop   = (state == S_EOP);

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_SYNC:   tx_byte = SYNC_BYTE;
      S_PID:    tx_byte = {~pid_q, pid_q};
      S_DATA:   tx_byte = fifo_data;
      S_CRC_LO: tx_byte = ~crc16[7:0];
      S_CRC_HI: tx_byte = ~crc16[15:8];
      default:  tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SYNC;
      S_SYNC:   if (tx_ready) state_nxt = S_PID;
      S_PID:    if (tx_ready) state_nxt = send_data_q ? S_DATA : S_EOP;
      S_DATA: begin
        // An empty counter means the length was wrong; close the packet with CRC.
        if (cnt_zero) state_nxt = S_CRC_LO;
        else if (tx_ready && cnt_one) state_nxt = S_CRC_LO;
      end
      S_CRC_LO: if (tx_ready) state_nxt = S_CRC_HI;
      S_CRC_HI: if (tx_ready) state_nxt = S_EOP;
      S_EOP:    if (tx_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (tx_busy && abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pid_q       <= 4'h0;
      send_data_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        pid_q       <= pid;
        send_data_q <= send_data;
        len_err_q   <= 1'b0;
      end else if (underflow) begin
        len_err_q <= 1'b1;
      end
    end
  end

endmodule
